// File: rtl/avalon_mm_mem_tester_pkg.sv
// mem_tester_pkg: shared types and helpers for the Avalon-MM memory tester.
//   state_t     - controller states
//   MODE_*      - mode bit encodings (fill / check)
//   LFSR_POLY   - Galois LFSR tap constant
//   lfsr_next() - one LFSR step
package mem_tester_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0]  MODE_FILL  = 2'b01;
  localparam logic [1:0]  MODE_CHECK = 2'b10;
  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/avalon_mm_mem_tester_if.sv
// avalon_mm_mem_tester_if: word-addressed Avalon-MM bus between the tester
// (master) and an on-chip RAM slave.
//   avm_address/byteenable/write/writedata/read : master -> slave
//   avm_readdata/readdatavalid/waitrequest      : slave -> master
interface avalon_mm_mem_tester_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_read;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_byteenable, avm_write, avm_writedata, avm_read,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_write, avm_writedata, avm_read,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/avalon_mm_mem_tester_lfsr.sv
// mem_tester_lfsr: 32-bit Galois LFSR pattern generator.
//   clk, reset_n : clock, synchronous active-low reset
//   load, seed   : load seed (a zero seed would lock up, so it becomes 1)
//   step         : advance one state (load has priority)
//   value        : current pattern word
module mem_tester_lfsr
  import mem_tester_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (!reset_n)  value <= '0;
    else if (load) value <= (seed == '0) ? 32'd1 : seed;
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/avalon_mm_mem_tester.sv
// avalon_mm_mem_tester: fills a word range of an Avalon-MM RAM with an LFSR
// pattern and/or reads it back counting mismatches.
//   clk, reset_n         : clock, synchronous active-low reset
//   start, mode          : one-cycle start (IDLE only); mode 01 fill, 10 check, 11 both
//   base_addr, word_count: word range (count 0..2^ADDR_W), addresses wrap
//   seed                 : pattern seed (0 behaves as 1)
//   busy, done           : busy while running; done pulses once at the end
//   err_count            : saturating mismatch count of the last check
//   first_err_addr       : address of the first mismatch
//   avm                  : Avalon-MM master port, one read outstanding at most
module avalon_mm_mem_tester
  import mem_tester_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  avalon_mm_mem_tester_if.master avm
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, base_q;
  logic [CNT_W-1:0]  remain_q, count_q;
  logic [31:0]       seed_q, lfsr_q;
  logic              check_q;
  logic              ld_start, ld_reload, advance, compare, wr, rd;
  logic              last, mismatch;

  assign last     = (remain_q == CNT_W'(1));
  assign mismatch = (avm.avm_readdata != lfsr_q[DATA_W-1:0]);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    wr        = 1'b0;
    rd        = 1'b0;
    ld_start  = 1'b0;
    ld_reload = 1'b0;
    advance   = 1'b0;
    compare   = 1'b0;
    unique case (state)
      S_IDLE: if (start) begin
        ld_start = 1'b1;
        if (word_count == '0 || mode == '0)   state_nxt = S_DONE;
        else if ((mode & MODE_FILL) != '0)    state_nxt = S_WRITE;
        else                                  state_nxt = S_READ_REQ;
      end
      S_WRITE: begin
        busy = 1'b1;
        wr   = 1'b1;
        if (!avm.avm_waitrequest) begin
          advance = 1'b1;
          if (last) begin
            if (check_q) begin
              // restart the same range and pattern for the readback pass
              ld_reload = 1'b1;
              state_nxt = S_READ_REQ;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
      end
      S_READ_REQ: begin
        busy = 1'b1;
        rd   = 1'b1;
        if (!avm.avm_waitrequest) state_nxt = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        busy = 1'b1;
        if (avm.avm_readdatavalid) begin
          compare   = 1'b1;
          advance   = 1'b1;
          state_nxt = last ? S_DONE : S_READ_REQ;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // requests drop as soon as reset is asserted, not one edge later
  assign avm.avm_write      = wr & reset_n;
  assign avm.avm_read       = rd & reset_n;
  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = lfsr_q;
  assign avm.avm_byteenable = 4'hF;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q   <= '0;
      base_q   <= '0;
      remain_q <= '0;
      count_q  <= '0;
      seed_q   <= '0;
      check_q  <= 1'b0;
    end else if (ld_start) begin
      addr_q   <= base_addr;
      base_q   <= base_addr;
      remain_q <= word_count;
      count_q  <= word_count;
      seed_q   <= seed;
      check_q  <= (mode & MODE_CHECK) != '0;
    end else if (ld_reload) begin
      addr_q   <= base_q;
      remain_q <= count_q;
    end else if (advance) begin
      addr_q   <= addr_q + ADDR_W'(1);
      remain_q <= remain_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || ld_start) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (compare && mismatch) begin
      if (err_count != '1) err_count      <= err_count + ERR_W'(1);
      if (err_count == '0) first_err_addr <= addr_q;
    end
  end

  mem_tester_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ld_start | ld_reload),
    .step    (advance),
    .seed    (ld_start ? seed : seed_q),
    .value   (lfsr_q)
  );

endmodule

// File: tb/tb_avalon_mm_mem_tester.sv
module tb_avalon_mm_mem_tester;

  localparam int ERR_W = 4;
  localparam logic [31:0] CORR = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [12:0]      base_addr = '0;
  logic [13:0]      word_count = '0;
  logic [31:0]      seed = '0;
  logic             busy, done;
  logic [ERR_W-1:0] err_count;
  logic [12:0]      first_err_addr;

  int total = 0;
  int bad   = 0;

  avalon_mm_mem_tester_if bus ();

  avalon_mm_mem_tester #(.ADDR_W(13), .DATA_W(32), .ERR_W(ERR_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm            (bus)
  );

  always #5 clk = ~clk;

  // on-chip RAM slave: 1-cycle read latency, optional random stalls and
  // a single corrupted address on readback
  logic [31:0] mem [0:8191];
  bit          stall_en = 0;
  bit          corrupt_en = 0;
  logic [12:0] corrupt_addr = '0;

  always @(posedge clk) begin
    bus.avm_readdatavalid <= 1'b0;
    if (bus.avm_write && !bus.avm_waitrequest) mem[bus.avm_address] <= bus.avm_writedata;
    if (bus.avm_read && !bus.avm_waitrequest) begin
      bus.avm_readdatavalid <= 1'b1;
      bus.avm_readdata <= mem[bus.avm_address] ^
                          ((corrupt_en && bus.avm_address == corrupt_addr) ? CORR : 32'h0);
    end
    bus.avm_waitrequest <= stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  // bus monitor: accepted beats, done pulses, request stability under stall
  logic [12:0] wr_addr_q[$], rd_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0, stall_seen = 0, stall_bad = 0;
  logic        p_rst = 1'b0, p_wait = 1'b0, p_w = 1'b0, p_r = 1'b0;
  logic [12:0] p_addr = '0;
  logic [31:0] p_wd = '0;

  always @(negedge clk) begin
    if (reset_n && bus.avm_write && !bus.avm_waitrequest) begin
      wr_addr_q.push_back(bus.avm_address);
      wr_data_q.push_back(bus.avm_writedata);
    end
    if (reset_n && bus.avm_read && !bus.avm_waitrequest) rd_addr_q.push_back(bus.avm_address);
    if (done) done_cnt <= done_cnt + 1;
    if (reset_n && p_rst && p_wait && (p_w || p_r)) begin
      stall_seen <= stall_seen + 1;
      if ({bus.avm_address, bus.avm_writedata, bus.avm_write, bus.avm_read} !== {p_addr, p_wd, p_w, p_r})
        stall_bad <= stall_bad + 1;
    end
    p_rst  <= reset_n;
    p_wait <= bus.avm_waitrequest;
    p_w    <= bus.avm_write;
    p_r    <= bus.avm_read;
    p_addr <= bus.avm_address;
    p_wd   <= bus.avm_writedata;
  end

  // reference model state: what the RAM should hold after each fill
  logic [31:0] exp_mem [int];

  function automatic logic [31:0] pat_next(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string nm, input logic [1:0] m, input int base, input int cnt,
                     input logic [31:0] sd, input bit stalls, input bit poke);
    int wr0, rd0, dn0, done_cyc, nwr, nrd, wbad, rbad, errs, a, exp_cyc;
    logic [31:0] v, seen;
    logic [12:0] first;
    bit active;
    wr0 = wr_addr_q.size(); rd0 = rd_addr_q.size(); dn0 = done_cnt;
    active = (cnt != 0) && (m != 2'b00);
    stall_en = stalls;
    mode = m; base_addr = 13'(base); word_count = 14'(cnt); seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 3000; c++) begin
      if (c == 1) begin
        chk({nm, "_busy_c1"}, busy, active);
        chk({nm, "_req_c1"}, bus.avm_write | bus.avm_read, active);
      end
      if (poke && c == 3) begin start = 1'b1; mode = 2'b00; word_count = 14'd1; end
      if (poke && c == 4) start = 1'b0;
      if (done) begin done_cyc = c; break; end
      @(negedge clk);
    end
    chk({nm, "_timeout"}, done_cyc > 0, 1'b1);
    chk({nm, "_busy_at_done"}, busy, 1'b0);
    if (!stalls) begin
      if (!active)          exp_cyc = 1;
      else if (m == 2'b01)  exp_cyc = cnt + 1;
      else if (m == 2'b10)  exp_cyc = 2 * cnt + 1;
      else                  exp_cyc = 3 * cnt + 1;
      chk({nm, "_done_cycle"}, done_cyc, exp_cyc);
    end
    @(negedge clk);
    stall_en = 0;
    chk({nm, "_done_pulses"}, done_cnt - dn0, 1);

    nwr = (active && m[0]) ? cnt : 0;
    nrd = (active && m[1]) ? cnt : 0;
    chk({nm, "_nwrites"}, wr_addr_q.size() - wr0, nwr);
    chk({nm, "_nreads"}, rd_addr_q.size() - rd0, nrd);
    v = (sd == 0) ? 32'd1 : sd;
    wbad = 0; rbad = 0; errs = 0; first = '0;
    for (int i = 0; i < cnt && active; i++) begin
      a = (base + i) % 8192;
      if (m[0]) begin
        exp_mem[a] = v;
        if (wr0 + i < wr_addr_q.size()) begin
          if (wr_addr_q[wr0 + i] !== 13'(a) || wr_data_q[wr0 + i] !== v) wbad++;
        end
      end
      if (m[1]) begin
        if (rd0 + i < rd_addr_q.size() && rd_addr_q[rd0 + i] !== 13'(a)) rbad++;
        seen = exp_mem[a] ^ ((corrupt_en && 13'(a) == corrupt_addr) ? CORR : 32'h0);
        if (seen !== v) begin
          if (errs == 0) first = 13'(a);
          errs++;
        end
      end
      v = pat_next(v);
    end
    chk({nm, "_write_trace"}, wbad, 0);
    chk({nm, "_read_trace"}, rbad, 0);
    chk({nm, "_err_count"}, err_count, (errs > 15) ? 15 : errs);
    chk({nm, "_first_err"}, first_err_addr, first);
  endtask

  initial begin
    logic [31:0] stall_seed, sd;
    logic [1:0]  m;
    bit          got;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_write", bus.avm_write, 1'b0);
    chk("rst_read", bus.avm_read, 1'b0);
    chk("rst_addr", bus.avm_address, 13'h0);
    chk("rst_wdata", bus.avm_writedata, 32'h0);
    chk("rst_err", err_count, 4'h0);
    chk("rst_first", first_err_addr, 13'h0);
    chk("rst_be", bus.avm_byteenable, 4'hF);
    reset_n = 1'b1;
    @(negedge clk);

    run("clean", 2'b11, 0, 4, 32'd1, 0, 0);
    chk("clean_word1", wr_data_q[1], 32'h8020_0003);

    corrupt_en = 1; corrupt_addr = 13'd2;
    run("inject", 2'b11, 0, 4, 32'd1, 0, 0);
    corrupt_en = 0;

    run("wrap", 2'b01, 13'h1FFE, 4, 32'h1234_5678, 0, 0);

    stall_seed = $urandom;
    run("stall", 2'b11, 100, 40, stall_seed, 1, 0);
    chk("stall_stable", stall_bad, 0);
    chk("stall_seen", stall_seen > 0, 1'b1);

    run("cnt0", 2'b11, 5, 0, 32'd7, 0, 0);
    run("mode00", 2'b00, 5, 4, 32'd7, 0, 0);
    run("busy_start", 2'b01, 200, 10, 32'd9, 0, 1);

    run("seed0_fill", 2'b01, 300, 6, 32'd0, 0, 0);
    run("seed1_check", 2'b10, 300, 6, 32'd1, 0, 0);

    run("saturate", 2'b10, 100, 40, stall_seed ^ 32'h5A5A_0001, 0, 0);

    for (int k = 0; k < 3; k++) begin
      m  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
      sd = $urandom;
      run("rand", m, $urandom_range(0, 8191), $urandom_range(1, 20), sd, $urandom_range(0, 1) == 1, 0);
    end

    // reset while a read is outstanding
    mode = 2'b11; base_addr = 13'd50; word_count = 14'd8; seed = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.avm_read && !bus.avm_waitrequest) begin got = 1; break; end
    end
    chk("rstmid_reach_read", got, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    chk("rstmid_read_drop", bus.avm_read, 1'b0);
    @(negedge clk);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_write", bus.avm_write, 1'b0);
    chk("rstmid_addr", bus.avm_address, 13'h0);
    chk("rstmid_wdata", bus.avm_writedata, 32'h0);
    chk("rstmid_err", err_count, 4'h0);
    reset_n = 1'b1;
    sd = 32'd5;
    for (int i = 0; i < 8; i++) begin exp_mem[50 + i] = sd; sd = pat_next(sd); end
    @(negedge clk);
    run("after_rst", 2'b11, 50, 8, 32'd5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
